risk_tile_walker: RTL and testbench

//  Command-side initiator for the RISK strided tile memory/register unit.

---
 rtl/risk_pkg.sv | 27 ++
 rtl/risk_tile_addr_gen.sv | 85 ++++++++
 rtl/risk_tile_walker.sv | 150 +++++++++++++++
 tb/tb_risk_tile_walker.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/risk_pkg.sv
// risk_pkg
//   Constants shared by the RISK tile walker, tile memory and register unit:
//   function encodings, tile edge size and the address/stride/register/
//   tile-count widths. No ports; imported with risk_pkg::*.
package risk_pkg;

  localparam int RISK_SZ       = 4;
  localparam int RISK_ADDR_W   = 15;
  localparam int RISK_STRIDE_W = 14;
  localparam int RISK_REG_W    = 5;
  localparam int RISK_DIM_W    = 8;
  localparam int RISK_HOLD     = 4;

  localparam logic [2:0] RISK_FUNC_LOAD  = 3'b000;
  localparam logic [2:0] RISK_FUNC_STORE = 3'b001;
  localparam logic [2:0] RISK_FUNC_ZERO  = 3'b010;
  localparam logic [2:0] RISK_FUNC_NOP   = 3'b111;

  // Any encoding other than load/store is issued as a zero-fill.
  function automatic logic [2:0] risk_func_map(input logic [2:0] f);
    case (f)
      RISK_FUNC_LOAD, RISK_FUNC_STORE: return f;
      default:                         return RISK_FUNC_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/risk_tile_addr_gen.sv
// risk_tile_addr_gen
//   Row-major tile index and address walker. On load it captures the grid
//   geometry and pre-scales the strides by SZ; each step advances to the
//   next tile using adds only.
// Ports:
//   clk, resetn         clock, asynchronous active-low reset
//   load                capture base/strides/tile counts, point at tile (0,0)
//   step                advance to the next tile (row-major)
//   base                element address of tile (0,0)
//   stride_x, stride_y  element strides
//   tiles_x, tiles_y    grid dimensions
//   addr                base address of the current tile
//   tile_x, tile_y      indices of the current tile
//   last_tile           current tile is the final tile of the grid
module risk_tile_addr_gen
  import risk_pkg::*;
#(
  parameter int SZ       = RISK_SZ,
  parameter int ADDR_W   = RISK_ADDR_W,
  parameter int STRIDE_W = RISK_STRIDE_W,
  parameter int DIM_W    = RISK_DIM_W
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                load,
  input  logic                step,
  input  logic [ADDR_W-1:0]   base,
  input  logic [STRIDE_W-1:0] stride_x,
  input  logic [STRIDE_W-1:0] stride_y,
  input  logic [DIM_W-1:0]    tiles_x,
  input  logic [DIM_W-1:0]    tiles_y,
  output logic [ADDR_W-1:0]   addr,
  output logic [DIM_W-1:0]    tile_x,
  output logic [DIM_W-1:0]    tile_y,
  output logic                last_tile
);

  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] step_x;
  logic [ADDR_W-1:0] step_y;
  logic [DIM_W-1:0]  last_x;
  logic [DIM_W-1:0]  last_y;

  // Only the low ADDR_W bits of SZ*stride matter because all address math
  // wraps modulo 2^ADDR_W; the product is formed once, at load.
  function automatic logic [ADDR_W-1:0] scale(input logic [STRIDE_W-1:0] s);
    return ADDR_W'(s) * ADDR_W'(SZ);
  endfunction

  assign last_tile = (tile_x == last_x) && (tile_y == last_y);

  // row_base tracks the start of the current row so a row wrap is one add.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      row_base <= '0;
      addr     <= '0;
      step_x   <= '0;
      step_y   <= '0;
      last_x   <= '0;
      last_y   <= '0;
      tile_x   <= '0;
      tile_y   <= '0;
    end else if (load) begin
      row_base <= base;
      addr     <= base;
      step_x   <= scale(stride_x);
      step_y   <= scale(stride_y);
      last_x   <= tiles_x - DIM_W'(1);
      last_y   <= tiles_y - DIM_W'(1);
      tile_x   <= '0;
      tile_y   <= '0;
    end else if (step) begin
      if (tile_x == last_x) begin
        tile_x   <= '0;
        tile_y   <= tile_y + DIM_W'(1);
        row_base <= row_base + step_y;
        addr     <= row_base + step_y;
      end else begin
        tile_x <= tile_x + DIM_W'(1);
        addr   <= addr + step_x;
      end
    end
  end

endmodule

// File: rtl/risk_tile_walker.sv
// risk_tile_walker
//   Command-side initiator for the RISK strided tile unit. Accepts one block
//   op via cmd_valid/cmd_ready, walks a tiles_x by tiles_y grid row-major and
//   holds each tile command for HOLD cycles to cover the tile memory pipeline.
// Ports:
//   clk, resetn                   clock, asynchronous active-low reset
//   cmd_valid / cmd_ready         command handshake (ready only when idle)
//   cmd_func, cmd_reg, cmd_base   op, RISK register, address of tile (0,0)
//   cmd_stride_x, cmd_stride_y    element strides
//   cmd_tiles_x, cmd_tiles_y      grid dimensions
//   abort                         synchronous cancel of a running op
//   risk_func, risk_reg           command to the RISK unit (NOP when idle)
//   risk_addr                     current tile base address
//   risk_stride_x, risk_stride_y  latched strides
//   tile_strobe                   pulse on the last hold cycle of each tile
//   tile_x, tile_y                indices of the tile being issued
//   done, aborted                 completion / cancellation pulses
module risk_tile_walker
  import risk_pkg::*;
#(
  parameter int SZ       = RISK_SZ,
  parameter int ADDR_W   = RISK_ADDR_W,
  parameter int STRIDE_W = RISK_STRIDE_W,
  parameter int REG_W    = RISK_REG_W,
  parameter int DIM_W    = RISK_DIM_W,
  parameter int HOLD     = RISK_HOLD
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [2:0]          cmd_func,
  input  logic [REG_W-1:0]    cmd_reg,
  input  logic [ADDR_W-1:0]   cmd_base,
  input  logic [STRIDE_W-1:0] cmd_stride_x,
  input  logic [STRIDE_W-1:0] cmd_stride_y,
  input  logic [DIM_W-1:0]    cmd_tiles_x,
  input  logic [DIM_W-1:0]    cmd_tiles_y,
  input  logic                abort,
  output logic [2:0]          risk_func,
  output logic [REG_W-1:0]    risk_reg,
  output logic [ADDR_W-1:0]   risk_addr,
  output logic [STRIDE_W-1:0] risk_stride_x,
  output logic [STRIDE_W-1:0] risk_stride_y,
  output logic                tile_strobe,
  output logic [DIM_W-1:0]    tile_x,
  output logic [DIM_W-1:0]    tile_y,
  output logic                done,
  output logic                aborted
);

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_ISSUE = 1'b1;

  localparam int              HOLD_W    = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD - 1);

  logic              state;
  logic [HOLD_W-1:0] hold;
  logic              accept;
  logic              empty_grid;
  logic              hold_end;
  logic              last_tile;
  logic              step;

  // abort blocks a same-cycle handshake even while idle.
  assign cmd_ready  = (state == ST_IDLE) && !abort;
  assign accept     = cmd_valid && cmd_ready;
  assign empty_grid = (cmd_tiles_x == '0) || (cmd_tiles_y == '0);
  assign hold_end   = (hold == HOLD_LAST);
  assign step       = (state == ST_ISSUE) && !abort && hold_end && !last_tile;

  risk_tile_addr_gen #(
    .SZ       (SZ),
    .ADDR_W   (ADDR_W),
    .STRIDE_W (STRIDE_W),
    .DIM_W    (DIM_W)
  ) u_addr_gen (
    .clk       (clk),
    .resetn    (resetn),
    .load      (accept),
    .step      (step),
    .base      (cmd_base),
    .stride_x  (cmd_stride_x),
    .stride_y  (cmd_stride_y),
    .tiles_x   (cmd_tiles_x),
    .tiles_y   (cmd_tiles_y),
    .addr      (risk_addr),
    .tile_x    (tile_x),
    .tile_y    (tile_y),
    .last_tile (last_tile)
  );

  // tile_strobe is registered, so it is set on the edge that moves the hold
  // counter onto its last value; abort always wins over a normal tile step.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= ST_IDLE;
      hold          <= '0;
      risk_func     <= RISK_FUNC_NOP;
      risk_reg      <= '0;
      risk_stride_x <= '0;
      risk_stride_y <= '0;
      tile_strobe   <= 1'b0;
      done          <= 1'b0;
      aborted       <= 1'b0;
    end else begin
      tile_strobe <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            risk_reg      <= cmd_reg;
            risk_stride_x <= cmd_stride_x;
            risk_stride_y <= cmd_stride_y;
            hold          <= '0;
            if (empty_grid) begin
              done <= 1'b1;
            end else begin
              state       <= ST_ISSUE;
              risk_func   <= risk_func_map(cmd_func);
              tile_strobe <= (HOLD == 1);
            end
          end
        end
        default: begin
          if (abort) begin
            state     <= ST_IDLE;
            risk_func <= RISK_FUNC_NOP;
            aborted   <= 1'b1;
          end else if (hold_end) begin
            if (last_tile) begin
              state     <= ST_IDLE;
              risk_func <= RISK_FUNC_NOP;
              done      <= 1'b1;
            end else begin
              hold        <= '0;
              tile_strobe <= (HOLD == 1);
            end
          end else begin
            hold        <= hold + HOLD_W'(1);
            tile_strobe <= ((hold + HOLD_W'(1)) == HOLD_LAST);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_risk_tile_walker.sv
// tb_risk_tile_walker
//   Self-checking bench for risk_tile_walker with HOLD=4, SZ=4. A table of
//   whole ops is walked cycle by cycle, followed by hand-written sequences
//   for abort, back-to-back acceptance and reset in the middle of an op.
module tb_risk_tile_walker;
  import risk_pkg::*;

  localparam int HOLD     = 4;
  localparam int SZ       = 4;
  localparam int ADDR_W   = 15;
  localparam int STRIDE_W = 14;
  localparam int REG_W    = 5;
  localparam int DIM_W    = 8;

  logic                clk = 1'b0;
  logic                resetn;
  logic                cmd_valid;
  logic                cmd_ready;
  logic [2:0]          cmd_func;
  logic [REG_W-1:0]    cmd_reg;
  logic [ADDR_W-1:0]   cmd_base;
  logic [STRIDE_W-1:0] cmd_stride_x;
  logic [STRIDE_W-1:0] cmd_stride_y;
  logic [DIM_W-1:0]    cmd_tiles_x;
  logic [DIM_W-1:0]    cmd_tiles_y;
  logic                abort;
  logic [2:0]          risk_func;
  logic [REG_W-1:0]    risk_reg;
  logic [ADDR_W-1:0]   risk_addr;
  logic [STRIDE_W-1:0] risk_stride_x;
  logic [STRIDE_W-1:0] risk_stride_y;
  logic                tile_strobe;
  logic [DIM_W-1:0]    tile_x;
  logic [DIM_W-1:0]    tile_y;
  logic                done;
  logic                aborted;

  int check_count = 0;
  int pass_count  = 0;

  typedef struct {
    logic [2:0]          func;
    logic [REG_W-1:0]    reg_idx;
    logic [ADDR_W-1:0]   base;
    logic [STRIDE_W-1:0] sx;
    logic [STRIDE_W-1:0] sy;
    logic [DIM_W-1:0]    tx;
    logic [DIM_W-1:0]    ty;
    logic [2:0]          exp_func;
    logic [ADDR_W-1:0]   exp_last_addr;
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  risk_tile_walker #(
    .SZ(SZ), .ADDR_W(ADDR_W), .STRIDE_W(STRIDE_W),
    .REG_W(REG_W), .DIM_W(DIM_W), .HOLD(HOLD)
  ) dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_func(cmd_func), .cmd_reg(cmd_reg), .cmd_base(cmd_base),
    .cmd_stride_x(cmd_stride_x), .cmd_stride_y(cmd_stride_y),
    .cmd_tiles_x(cmd_tiles_x), .cmd_tiles_y(cmd_tiles_y),
    .abort(abort),
    .risk_func(risk_func), .risk_reg(risk_reg), .risk_addr(risk_addr),
    .risk_stride_x(risk_stride_x), .risk_stride_y(risk_stride_y),
    .tile_strobe(tile_strobe), .tile_x(tile_x), .tile_y(tile_y),
    .done(done), .aborted(aborted)
  );

  // One comparison: bumps the counters and reports any difference.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Reference address of tile (x,y): direct product form, wrapped to ADDR_W.
  function automatic logic [ADDR_W-1:0] model_addr(input vec_t v, input int x, input int y);
    longint a;
    a = longint'(v.base) + longint'(SZ) * (longint'(v.sx) * x + longint'(v.sy) * y);
    return a[ADDR_W-1:0];
  endfunction

  // Puts a command on the cmd_* inputs and raises cmd_valid.
  task automatic applyStimulus(input vec_t v);
    cmd_func     = v.func;
    cmd_reg      = v.reg_idx;
    cmd_base     = v.base;
    cmd_stride_x = v.sx;
    cmd_stride_y = v.sy;
    cmd_tiles_x  = v.tx;
    cmd_tiles_y  = v.ty;
    cmd_valid    = 1'b1;
  endtask

  // Every output that must sit at its reset value.
  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_func"},    32'(risk_func), 32'(RISK_FUNC_NOP));
    checkOutput({tag, "_reg"},     32'(risk_reg), 0);
    checkOutput({tag, "_addr"},    32'(risk_addr), 0);
    checkOutput({tag, "_sx"},      32'(risk_stride_x), 0);
    checkOutput({tag, "_sy"},      32'(risk_stride_y), 0);
    checkOutput({tag, "_tile_x"},  32'(tile_x), 0);
    checkOutput({tag, "_tile_y"},  32'(tile_y), 0);
    checkOutput({tag, "_strobe"},  32'(tile_strobe), 0);
    checkOutput({tag, "_done"},    32'(done), 0);
    checkOutput({tag, "_aborted"}, 32'(aborted), 0);
    checkOutput({tag, "_ready"},   32'(cmd_ready), 1);
  endtask

  // Runs one table op from a negedge, checking every hold cycle and the done pulse.
  task automatic runVector(input int idx, input vec_t v);
    int n;
    int t;
    int h;
    string p;
    p = $sformatf("v%0d", idx);
    n = int'(v.tx) * int'(v.ty);
    applyStimulus(v);
    @(negedge clk);
    cmd_valid = 1'b0;
    if (n == 0) begin
      checkOutput({p, "_empty_done"},   32'(done), 1);
      checkOutput({p, "_empty_func"},   32'(risk_func), 32'(RISK_FUNC_NOP));
      checkOutput({p, "_empty_ready"},  32'(cmd_ready), 1);
      checkOutput({p, "_empty_strobe"}, 32'(tile_strobe), 0);
      @(negedge clk);
      checkOutput({p, "_empty_done_clr"}, 32'(done), 0);
      checkOutput({p, "_empty_func2"},    32'(risk_func), 32'(RISK_FUNC_NOP));
      checkOutput({p, "_empty_ready2"},   32'(cmd_ready), 1);
      return;
    end
    for (int c = 0; c < n * HOLD; c++) begin
      t = c / HOLD;
      h = c % HOLD;
      if (c > 0) @(negedge clk);
      checkOutput($sformatf("%s_c%0d_strobe", p, c), 32'(tile_strobe), 32'(h == HOLD - 1));
      if (h == 0) begin
        checkOutput($sformatf("%s_t%0d_func", p, t),   32'(risk_func), 32'(v.exp_func));
        checkOutput($sformatf("%s_t%0d_reg", p, t),    32'(risk_reg), 32'(v.reg_idx));
        checkOutput($sformatf("%s_t%0d_addr", p, t),   32'(risk_addr),
                    32'(model_addr(v, t % int'(v.tx), t / int'(v.tx))));
        checkOutput($sformatf("%s_t%0d_x", p, t),      32'(tile_x), 32'(t % int'(v.tx)));
        checkOutput($sformatf("%s_t%0d_y", p, t),      32'(tile_y), 32'(t / int'(v.tx)));
        checkOutput($sformatf("%s_t%0d_sx", p, t),     32'(risk_stride_x), 32'(v.sx));
        checkOutput($sformatf("%s_t%0d_sy", p, t),     32'(risk_stride_y), 32'(v.sy));
        checkOutput($sformatf("%s_t%0d_ready", p, t),  32'(cmd_ready), 0);
        checkOutput($sformatf("%s_t%0d_done", p, t),   32'(done), 0);
        if (t == n - 1)
          checkOutput({p, "_last_addr"}, 32'(risk_addr), 32'(v.exp_last_addr));
      end
    end
    @(negedge clk);
    checkOutput({p, "_done"},       32'(done), 1);
    checkOutput({p, "_done_func"},  32'(risk_func), 32'(RISK_FUNC_NOP));
    checkOutput({p, "_done_ready"}, 32'(cmd_ready), 1);
    checkOutput({p, "_done_strobe"}, 32'(tile_strobe), 0);
    @(negedge clk);
    checkOutput({p, "_done_clr"},   32'(done), 0);
  endtask

  // Main sequence: reset, table walk, then the multi-cycle corner cases.
  initial begin
    vec_t v;
    int strobes;
    resetn       = 1'b0;
    cmd_valid    = 1'b0;
    cmd_func     = '0;
    cmd_reg      = '0;
    cmd_base     = '0;
    cmd_stride_x = '0;
    cmd_stride_y = '0;
    cmd_tiles_x  = '0;
    cmd_tiles_y  = '0;
    abort        = 1'b0;

    //        func    reg    base        sx         sy      tx    ty   exp_func         last addr
    vecs[0] = '{3'b000, 5'd2,  15'h0010, 14'd1,     14'd32, 8'd1, 8'd1, RISK_FUNC_LOAD,  15'h0010};
    vecs[1] = '{3'b001, 5'd0,  15'h0000, 14'd1,     14'd32, 8'd2, 8'd2, RISK_FUNC_STORE, 15'h0084};
    vecs[2] = '{3'b010, 5'd7,  15'h7FFC, 14'd1,     14'd0,  8'd2, 8'd1, RISK_FUNC_ZERO,  15'h0000};
    vecs[3] = '{3'b000, 5'd1,  15'h0000, 14'd1,     14'd1,  8'd0, 8'd3, RISK_FUNC_NOP,   15'h0000};
    vecs[4] = '{3'b101, 5'd31, 15'h0100, 14'd3,     14'd5,  8'd1, 8'd2, RISK_FUNC_ZERO,  15'h0114};
    vecs[5] = '{3'b001, 5'd3,  15'h0123, 14'h3FFF,  14'h10, 8'd3, 8'd1, RISK_FUNC_STORE, 15'h011B};
    vecs[6] = '{3'b000, 5'd4,  15'h0040, 14'd2,     14'd2,  8'd2, 8'd0, RISK_FUNC_NOP,   15'h0000};

    @(negedge clk);
    checkResetValues("reset");
    resetn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) runVector(i, vecs[i]);

    // Abort during the second tile of a 3x1 op: one strobe, aborted, no done.
    v = '{3'b000, 5'd4, 15'h0200, 14'd1, 14'd1, 8'd3, 8'd1, RISK_FUNC_LOAD, 15'h0208};
    applyStimulus(v);
    strobes = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) cmd_valid = 1'b0;
      if (tile_strobe) strobes++;
      if (c == 5) begin
        checkOutput("abort_t1_addr", 32'(risk_addr), 32'h204);
        checkOutput("abort_t1_x",    32'(tile_x), 1);
      end
    end
    abort = 1'b1;
    @(negedge clk);
    if (tile_strobe) strobes++;
    checkOutput("abort_pulse",      32'(aborted), 1);
    checkOutput("abort_no_done",    32'(done), 0);
    checkOutput("abort_func",       32'(risk_func), 32'(RISK_FUNC_NOP));
    checkOutput("abort_strobe",     32'(tile_strobe), 0);
    checkOutput("abort_ready_held", 32'(cmd_ready), 0);
    abort = 1'b0;
    #1;
    checkOutput("abort_ready", 32'(cmd_ready), 1);
    @(negedge clk);
    if (tile_strobe) strobes++;
    checkOutput("abort_pulse_clr", 32'(aborted), 0);
    checkOutput("abort_done_clr",  32'(done), 0);
    checkOutput("abort_strobes",   32'(strobes), 1);

    // abort while idle blocks the handshake and produces no pulse.
    applyStimulus(vecs[0]);
    abort = 1'b1;
    #1;
    checkOutput("idle_abort_ready", 32'(cmd_ready), 0);
    @(negedge clk);
    checkOutput("idle_abort_func",    32'(risk_func), 32'(RISK_FUNC_NOP));
    checkOutput("idle_abort_done",    32'(done), 0);
    checkOutput("idle_abort_aborted", 32'(aborted), 0);
    cmd_valid = 1'b0;
    abort     = 1'b0;
    @(negedge clk);
    checkOutput("idle_abort_func2", 32'(risk_func), 32'(RISK_FUNC_NOP));

    // cmd_valid held high: second command taken in the done cycle, then reset mid-op.
    v = '{3'b000, 5'd6, 15'h0020, 14'd1, 14'd1, 8'd1, 8'd1, RISK_FUNC_LOAD, 15'h0020};
    applyStimulus(v);
    @(negedge clk);
    checkOutput("b2b_a_func", 32'(risk_func), 32'(RISK_FUNC_LOAD));
    checkOutput("b2b_a_addr", 32'(risk_addr), 32'h20);
    v = '{3'b001, 5'd9, 15'h0040, 14'd2, 14'd1, 8'd2, 8'd1, RISK_FUNC_STORE, 15'h0048};
    applyStimulus(v);
    @(negedge clk);
    @(negedge clk);
    checkOutput("b2b_a_reg_stable", 32'(risk_reg), 6);
    checkOutput("b2b_a_busy",       32'(cmd_ready), 0);
    @(negedge clk);
    checkOutput("b2b_a_strobe", 32'(tile_strobe), 1);
    @(negedge clk);
    checkOutput("b2b_a_done",  32'(done), 1);
    checkOutput("b2b_a_ready", 32'(cmd_ready), 1);
    @(negedge clk);
    checkOutput("b2b_b_func", 32'(risk_func), 32'(RISK_FUNC_STORE));
    checkOutput("b2b_b_reg",  32'(risk_reg), 9);
    checkOutput("b2b_b_addr", 32'(risk_addr), 32'h40);
    checkOutput("b2b_b_done", 32'(done), 0);
    @(negedge clk);
    resetn    = 1'b0;
    cmd_valid = 1'b0;
    #1;
    checkResetValues("midreset");
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    checkOutput("midreset_no_done",    32'(done), 0);
    checkOutput("midreset_no_aborted", 32'(aborted), 0);
    checkOutput("midreset_func",       32'(risk_func), 32'(RISK_FUNC_NOP));

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
